// File: rtl/instr_fetch_decode_ctrl_if.sv
// Instruction-memory fetch port: the controller drives the address and request,
// and the memory answers with ack and the instruction word.
interface instr_fetch_decode_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (output imem_addr, output imem_req, input imem_ack, input imem_rdata);
    modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/control for an RV32I subset (ADDI, ADD, SUB, LW, SW).
// Optional macro BRANCH_EN adds BEQ, which is resolved in EXEC using alu_zero.
module instr_fetch_decode_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              REG_AW   = 5,
    parameter int              PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_decode_ctrl_if.master imem,
    output logic [REG_AW-1:0]        ra,
    output logic [REG_AW-1:0]        rb,
    output logic [REG_AW-1:0]        rw,
    output logic [XLEN-1:0]          imm,
    output logic                     we_reg,
    output logic                     we_mem,
    output logic                     op_mem,
    output logic                     add_sub,
    input  logic                     alu_zero,
    output logic                     illegal,
    output logic [31:0]              instret
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
    typedef enum logic [1:0] {K_ALU, K_LW, K_SW, K_BEQ} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       instret_q, instret_d;
    logic              illegal_q, illegal_d;
    logic [REG_AW-1:0] ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              we_reg_q, we_reg_d, we_mem_q, we_mem_d;
    logic              op_mem_q, op_mem_d, add_sub_q, add_sub_d;

    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic              is_addi, is_rr, is_lw, is_sw, is_beq;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, step;

    assign opc  = ir_q[6:0];
    assign f3   = ir_q[14:12];
    assign f7   = ir_q[31:25];
    assign step = XLEN'(PC_STEP);

    assign imm_i = XLEN'($signed(ir_q[31:20]));
    assign imm_s = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
    assign imm_b = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));

    assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_rr   = (opc == 7'b0110011) && (f3 == 3'b000) &&
                     ((f7 == 7'b0000000) || (f7 == 7'b0100000));
    assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
    assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
`ifdef BRANCH_EN
    assign is_beq  = (opc == 7'b1100011) && (f3 == 3'b000);
`else
    logic unused_alu_zero;
    assign is_beq          = 1'b0;
    assign unused_alu_zero = alu_zero;
`endif

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        illegal_d = illegal_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rw_d      = rw_q;
        imm_d     = imm_q;
        op_mem_d  = op_mem_q;
        add_sub_d = add_sub_q;
        we_reg_d  = 1'b0;
        we_mem_d  = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ra_d      = REG_AW'(ir_q[19:15]);
                rb_d      = REG_AW'(ir_q[24:20]);
                rw_d      = REG_AW'(ir_q[11:7]);
                imm_d     = is_sw ? imm_s : (is_beq ? imm_b : imm_i);
                add_sub_d = (is_rr && f7[5]) || is_beq;
                op_mem_d  = is_lw;
                // Strobes are registered here so they are high during the EXEC cycle.
                if (is_addi || is_rr || is_lw || is_sw || is_beq) begin
                    kind_d   = is_lw ? K_LW : (is_sw ? K_SW : (is_beq ? K_BEQ : K_ALU));
                    we_reg_d = is_addi || is_rr;
                    we_mem_d = is_sw;
                    state_d  = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    pc_d      = pc_q + step;
                    state_d   = FETCH;
                end
            end
            EXEC: begin
                if (kind_q == K_LW) begin
                    state_d = MEM;
                end else begin
                    pc_d = pc_q + step;
`ifdef BRANCH_EN
                    if (kind_q == K_BEQ && alu_zero) pc_d = pc_q + imm_q;
`endif
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            MEM: begin
                we_reg_d = 1'b1;
                state_d  = WB;
            end
            WB: begin
                pc_d      = pc_q + step;
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            kind_q    <= K_ALU;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            imm_q     <= '0;
            we_reg_q  <= 1'b0;
            we_mem_q  <= 1'b0;
            op_mem_q  <= 1'b0;
            add_sub_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rw_q      <= rw_d;
            imm_q     <= imm_d;
            we_reg_q  <= we_reg_d;
            we_mem_q  <= we_mem_d;
            op_mem_q  <= op_mem_d;
            add_sub_q <= add_sub_d;
        end
    end

    // Gating with reset keeps the request low while held in reset, yet lets a
    // zero-wait fetch complete in the very first cycle after release.
    assign imem.imem_req  = (state_q == FETCH) && reset;
    assign imem.imem_addr = pc_q;

    assign ra      = ra_q;
    assign rb      = rb_q;
    assign rw      = rw_q;
    assign imm     = imm_q;
    assign we_reg  = we_reg_q;
    assign we_mem  = we_mem_q;
    assign op_mem  = op_mem_q;
    assign add_sub = add_sub_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_instr_fetch_decode_ctrl.sv
// Directed bench for instr_fetch_decode_ctrl (default build, BRANCH_EN undefined).
module tb_instr_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ra, rb, rw;
    logic [31:0] imm;
    logic        we_reg, we_mem, op_mem, add_sub, illegal;
    logic        alu_zero = 1'b0;
    logic [31:0] instret;

    instr_fetch_decode_ctrl_if #(.XLEN(32)) imem ();

    instr_fetch_decode_ctrl dut (
        .clk(clk), .reset(reset), .imem(imem),
        .ra(ra), .rb(rb), .rw(rw), .imm(imm),
        .we_reg(we_reg), .we_mem(we_mem), .op_mem(op_mem), .add_sub(add_sub),
        .alu_zero(alu_zero), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int req_cnt, wr_cnt, wm_cnt, cyc;
    logic wr_opmem;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (imem.imem_req) req_cnt++;
        if (we_reg) begin wr_cnt++; wr_opmem = op_mem; end
        if (we_mem) wm_cnt++;
    endtask

    // Called at a negedge in FETCH; returns at the negedge of the next FETCH.
    task automatic issue(input logic [31:0] instr, input int dly);
        int n;
        req_cnt = 0; wr_cnt = 0; wm_cnt = 0; wr_opmem = 1'b0; cyc = 0; n = 0;
        for (int i = 0; i <= dly; i++) begin
            sample();
            imem.imem_ack   = (i == dly);
            imem.imem_rdata = instr;
            @(negedge clk);
            cyc++;
        end
        imem.imem_ack = 1'b0;
        while (!imem.imem_req && n < 20) begin
            sample();
            @(negedge clk);
            cyc++; n++;
        end
        if (!imem.imem_req) chk("fetch_tmo", imem.imem_req, 1'b1);
    endtask

    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",     imem.imem_req, 0);
        chk("rst_addr",    imem.imem_addr, 0);
        chk("rst_instret", instret, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_fields",  {ra, rb, rw, imm, we_reg, we_mem, op_mem, add_sub}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("req_after_rst", imem.imem_req, 1);

        issue(32'h00500093, 0);              // ADDI x1,x0,5
        chk("addi_cyc", cyc, 3);
        chk("addi_rw",  rw, 1);
        chk("addi_ra",  ra, 0);
        chk("addi_imm", imm, 5);
        chk("addi_wr",  wr_cnt, 1);
        chk("addi_opm", wr_opmem, 0);
        chk("addi_wm",  wm_cnt, 0);
        chk("addi_pc",  imem.imem_addr, 4);
        chk("addi_ret", instret, 1);

        issue(32'h002081B3, 0);              // ADD x3,x1,x2
        chk("add_regs", {ra, rb, rw}, {5'd1, 5'd2, 5'd3});
        chk("add_as",   add_sub, 0);
        chk("add_wr",   wr_cnt, 1);
        chk("add_pc",   imem.imem_addr, 8);

        issue(32'h402081B3, 0);              // SUB x3,x1,x2
        chk("sub_as",   add_sub, 1);
        chk("sub_wr",   wr_cnt, 1);
        chk("sub_pc",   imem.imem_addr, 12);
        chk("sub_ret",  instret, 3);

        issue(32'h00802283, 3);              // LW x5,8(x0), ack after 3 waits
        chk("lw_req",   req_cnt, 4);
        chk("lw_cyc",   cyc, 8);
        chk("lw_rw",    rw, 5);
        chk("lw_imm",   imm, 8);
        chk("lw_wr",    wr_cnt, 1);
        chk("lw_opm",   wr_opmem, 1);
        chk("lw_pc",    imem.imem_addr, 16);
        chk("lw_ret",   instret, 4);

        issue(32'h00502623, 0);              // SW x5,12(x0)
        chk("sw_regs",  {ra, rb}, {5'd0, 5'd5});
        chk("sw_imm",   imm, 12);
        chk("sw_wm",    wm_cnt, 1);
        chk("sw_wr",    wr_cnt, 0);
        chk("sw_cyc",   cyc, 3);
        chk("sw_pc",    imem.imem_addr, 20);

        issue(32'hFFF00093, 0);              // ADDI x1,x0,-1
        chk("neg_imm",  imm, 32'hFFFF_FFFF);
        chk("neg_ret",  instret, 6);

        issue(32'hFFFFFFFF, 0);              // unsupported
        chk("ill_flag", illegal, 1);
        chk("ill_strb", {wr_cnt[3:0], wm_cnt[3:0]}, 0);
        chk("ill_cyc",  cyc, 2);
        chk("ill_pc",   imem.imem_addr, 28);
        chk("ill_ret",  instret, 6);

        issue(32'h00500093, 0);
        chk("ill_sticky", illegal, 1);
        chk("ill_next_pc", imem.imem_addr, 32);

        // Reset asserted in FETCH with an ack pending: the ack must be dropped.
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h00500093;
        reset           = 1'b0;
        @(negedge clk);
        chk("mrst_req",  imem.imem_req, 0);
        chk("mrst_pc",   imem.imem_addr, 0);
        chk("mrst_ret",  instret, 0);
        chk("mrst_ill",  illegal, 0);
        chk("mrst_strb", {we_reg, we_mem}, 0);
        imem.imem_ack = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        chk("mrst_fetch", imem.imem_req, 1);

        issue(32'h00000463, 0);              // BEQ x0,x0,8: illegal in this build
        chk("beq_ill",  illegal, 1);
        chk("beq_cyc",  cyc, 2);
        chk("beq_pc",   imem.imem_addr, 4);
        chk("beq_ret",  instret, 0);
        chk("beq_strb", {wr_cnt[3:0], wm_cnt[3:0]}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
